// File: rtl/set_cache_miss_sequencer_if.sv
// Miss-sequencer bundle: cache pipeline request, policy controller handshake,
// metadata port, writeback/fill memory port and completion status.
interface set_cache_miss_sequencer_if #(
    parameter int CACHE_BLOCK_CAPACITY = 128,
    parameter int CACHE_SET_SIZE       = 4,
    parameter int BW_TAG               = 20
);
    localparam int BW_CAP      = $clog2(CACHE_BLOCK_CAPACITY);
    localparam bit FULLY_ASSOC = (CACHE_SET_SIZE == CACHE_BLOCK_CAPACITY);
    localparam int BW_GRP      = FULLY_ASSOC ? 1 : BW_CAP - $clog2(CACHE_SET_SIZE);

    logic                     req_valid_i;
    logic                     req_ready_o;
    logic [BW_GRP-1:0]        req_group_i;
    logic [BW_TAG-1:0]        req_tag_i;
    logic                     pol_miss_o;
    logic [BW_GRP-1:0]        pol_group_o;
    logic                     pol_done_i;
    logic [BW_CAP-1:0]        pol_addr_i;
    logic [BW_CAP-1:0]        meta_addr_o;
    logic                     meta_valid_i;
    logic                     meta_dirty_i;
    logic [BW_TAG-1:0]        meta_tag_i;
    logic                     meta_we_o;
    logic [BW_TAG-1:0]        meta_tag_o;
    logic                     wb_req_o;
    logic [BW_TAG+BW_GRP-1:0] wb_addr_o;
    logic                     wb_ack_i;
    logic                     fill_req_o;
    logic [BW_TAG+BW_GRP-1:0] fill_addr_o;
    logic                     fill_ack_i;
    logic                     done_o;
    logic [BW_CAP-1:0]        victim_o;

    modport master (
        input  req_valid_i, req_group_i, req_tag_i, pol_done_i, pol_addr_i,
               meta_valid_i, meta_dirty_i, meta_tag_i, wb_ack_i, fill_ack_i,
        output req_ready_o, pol_miss_o, pol_group_o, meta_addr_o, meta_we_o,
               meta_tag_o, wb_req_o, wb_addr_o, fill_req_o, fill_addr_o,
               done_o, victim_o
    );

    modport slave (
        output req_valid_i, req_group_i, req_tag_i, pol_done_i, pol_addr_i,
               meta_valid_i, meta_dirty_i, meta_tag_i, wb_ack_i, fill_ack_i,
        input  req_ready_o, pol_miss_o, pol_group_o, meta_addr_o, meta_we_o,
               meta_tag_o, wb_req_o, wb_addr_o, fill_req_o, fill_addr_o,
               done_o, victim_o
    );
endinterface

// File: rtl/set_cache_miss_sequencer.sv
// Cache miss sequencer: policy query, victim metadata read, optional writeback, fill, metadata update.
// Define MISS_SEQ_STATS_EN to add saturating miss / writeback counters (stat_miss_o, stat_wb_o).
//
//  state  | meaning
//  IDLE   | ready for a miss request
//  POL    | pulsing pol_miss_o to the policy controller
//  CAP    | waiting for pol_done_i, metadata address follows pol_addr_i
//  META   | victim metadata read data valid, choose WB or FILL
//  WB     | writeback of dirty victim outstanding
//  FILL   | fill of missing block outstanding
//  UPD    | metadata write for the new block
//  DONE   | completion pulse
module set_cache_miss_sequencer #(
    parameter int CACHE_BLOCK_CAPACITY = 128,
    parameter int CACHE_SET_SIZE       = 4,
    parameter int BW_TAG               = 20
) (
    input  logic clock_i,
    input  logic reset_i,
    set_cache_miss_sequencer_if.master mif
`ifdef MISS_SEQ_STATS_EN
    ,
    output logic [31:0] stat_miss_o,
    output logic [31:0] stat_wb_o
`endif
);
    localparam int BW_CAP      = $clog2(CACHE_BLOCK_CAPACITY);
    localparam bit FULLY_ASSOC = (CACHE_SET_SIZE == CACHE_BLOCK_CAPACITY);
    localparam int BW_GRP      = FULLY_ASSOC ? 1 : BW_CAP - $clog2(CACHE_SET_SIZE);

    typedef enum logic [2:0] {
        S_IDLE, S_POL, S_CAP, S_META, S_WB, S_FILL, S_UPD, S_DONE
    } state_t;

    state_t                   state;
    logic [BW_GRP-1:0]        group_q;
    logic [BW_TAG-1:0]        tag_q;
    logic [BW_CAP-1:0]        victim_q;
    logic                     req_ready;
    logic                     pol_miss;
    logic [BW_GRP-1:0]        pol_group;
    logic                     meta_we;
    logic [BW_TAG-1:0]        meta_tag;
    logic                     wb_req;
    logic [BW_TAG+BW_GRP-1:0] wb_addr;
    logic                     fill_req;
    logic [BW_TAG+BW_GRP-1:0] fill_addr;
    logic                     done;
    logic [BW_CAP-1:0]        victim_out;
    logic [BW_GRP-1:0]        grp_in;
    logic                     accept;

    assign grp_in = FULLY_ASSOC ? '0 : mif.req_group_i;
    assign accept = (state == S_IDLE) && mif.req_valid_i && req_ready;

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state      <= S_IDLE;
            group_q    <= '0;
            tag_q      <= '0;
            victim_q   <= '0;
            req_ready  <= 1'b0;
            pol_miss   <= 1'b0;
            pol_group  <= '0;
            meta_we    <= 1'b0;
            meta_tag   <= '0;
            wb_req     <= 1'b0;
            wb_addr    <= '0;
            fill_req   <= 1'b0;
            fill_addr  <= '0;
            done       <= 1'b0;
            victim_out <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        group_q   <= grp_in;
                        tag_q     <= mif.req_tag_i;
                        pol_group <= grp_in;
                        pol_miss  <= 1'b1;
                        req_ready <= 1'b0;
                        state     <= S_POL;
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                S_POL: begin
                    pol_miss <= 1'b0;
                    state    <= S_CAP;
                end
                S_CAP: begin
                    if (mif.pol_done_i) begin
                        victim_q  <= mif.pol_addr_i;
                        pol_group <= '0;
                        state     <= S_META;
                    end
                end
                S_META: begin
                    if (mif.meta_valid_i && mif.meta_dirty_i) begin
                        wb_req  <= 1'b1;
                        wb_addr <= {mif.meta_tag_i, group_q};
                        state   <= S_WB;
                    end else begin
                        fill_req  <= 1'b1;
                        fill_addr <= {tag_q, group_q};
                        state     <= S_FILL;
                    end
                end
                S_WB: begin
                    // fill_ack_i is deliberately not looked at here
                    if (mif.wb_ack_i) begin
                        wb_req    <= 1'b0;
                        fill_req  <= 1'b1;
                        fill_addr <= {tag_q, group_q};
                        state     <= S_FILL;
                    end
                end
                S_FILL: begin
                    if (mif.fill_ack_i) begin
                        fill_req <= 1'b0;
                        meta_we  <= 1'b1;
                        meta_tag <= tag_q;
                        state    <= S_UPD;
                    end
                end
                S_UPD: begin
                    meta_we    <= 1'b0;
                    done       <= 1'b1;
                    victim_out <= victim_q;
                    state      <= S_DONE;
                end
                S_DONE: begin
                    done      <= 1'b0;
                    req_ready <= 1'b1;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef MISS_SEQ_STATS_EN
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            stat_miss_o <= '0;
            stat_wb_o   <= '0;
        end else begin
            if (accept && (stat_miss_o != 32'hFFFF_FFFF))
                stat_miss_o <= stat_miss_o + 32'd1;
            if ((state == S_WB) && mif.wb_ack_i && (stat_wb_o != 32'hFFFF_FFFF))
                stat_wb_o <= stat_wb_o + 32'd1;
        end
    end
`endif

    assign mif.req_ready_o = req_ready;
    assign mif.pol_miss_o  = pol_miss;
    assign mif.pol_group_o = pol_group;
    // Metadata address leads the capture by a cycle so the 1-cycle read lands in META
    assign mif.meta_addr_o = (state == S_CAP) ? mif.pol_addr_i : victim_q;
    assign mif.meta_we_o   = meta_we;
    assign mif.meta_tag_o  = meta_tag;
    assign mif.wb_req_o    = wb_req;
    assign mif.wb_addr_o   = wb_addr;
    assign mif.fill_req_o  = fill_req;
    assign mif.fill_addr_o = fill_addr;
    assign mif.done_o      = done;
    assign mif.victim_o    = victim_out;
endmodule

// File: tb/tb_set_cache_miss_sequencer.sv
// Scoreboard bench for set_cache_miss_sequencer: responder models for policy,
// metadata store and memory port; expectations queued on accept, checked on done_o.
module tb_set_cache_miss_sequencer;
    localparam int CAP    = 128;
    localparam int SET    = 4;
    localparam int BW_TAG = 20;
    localparam int BW_CAP = 7;
    localparam int BW_GRP = 5;

    logic clock_i = 1'b0;
    logic reset_i = 1'b1;
    always #5 clock_i = ~clock_i;

    set_cache_miss_sequencer_if #(.CACHE_BLOCK_CAPACITY(CAP), .CACHE_SET_SIZE(SET), .BW_TAG(BW_TAG)) mif ();

    set_cache_miss_sequencer #(.CACHE_BLOCK_CAPACITY(CAP), .CACHE_SET_SIZE(SET), .BW_TAG(BW_TAG)) dut (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .mif     (mif)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [BW_CAP-1:0] victim;
        logic [BW_TAG-1:0] tag;
        logic [BW_GRP-1:0] grp;
        bit                dirty;
        logic [BW_TAG-1:0] old_tag;
        int                lat;
        int                t_acc;
    } exp_t;

    exp_t sb[$];

    int cyc = 0;
    always @(posedge clock_i) cyc <= cyc + 1;

    // metadata store, 1-cycle read latency
    logic              m_valid [CAP];
    logic              m_dirty [CAP];
    logic [BW_TAG-1:0] m_tag   [CAP];

    always @(posedge clock_i) begin
        mif.meta_valid_i <= m_valid[mif.meta_addr_o];
        mif.meta_dirty_i <= m_dirty[mif.meta_addr_o];
        mif.meta_tag_i   <= m_tag[mif.meta_addr_o];
        if (mif.meta_we_o) begin
            m_valid[mif.meta_addr_o] <= 1'b1;
            m_dirty[mif.meta_addr_o] <= 1'b0;
            m_tag[mif.meta_addr_o]   <= mif.meta_tag_o;
        end
    end

    task automatic set_meta(input int a, input bit v, input bit d, input logic [BW_TAG-1:0] t);
        m_valid[a] <= v;
        m_dirty[a] <= d;
        m_tag[a]   <= t;
    endtask

    // responder configuration
    logic [BW_CAP-1:0] cur_victim = '0;
    int pol_delay = 0, wb_delay = 0, fill_delay = 0;
    bit both_ack = 0, stray_ack = 0;
    int wb_ack_cyc = -10;

    bit pol_pend = 0;
    int pol_wait = 0, wb_cnt = 0, fill_cnt = 0;

    always @(negedge clock_i) begin
        mif.pol_done_i = 1'b0;
        mif.pol_addr_i = ~cur_victim;
        mif.wb_ack_i   = 1'b0;
        mif.fill_ack_i = 1'b0;
        if (reset_i) begin
            pol_pend = 0;
            wb_cnt   = 0;
            fill_cnt = 0;
        end else begin
            if (pol_pend) begin
                if (pol_wait == 0) begin
                    mif.pol_done_i = 1'b1;
                    mif.pol_addr_i = cur_victim;
                    pol_pend = 0;
                end else begin
                    pol_wait--;
                end
            end
            if (mif.pol_miss_o) begin
                pol_pend = 1;
                pol_wait = pol_delay;
            end
            if (mif.wb_req_o) begin
                if (wb_cnt == wb_delay) begin
                    mif.wb_ack_i = 1'b1;
                    if (both_ack) mif.fill_ack_i = 1'b1;
                    wb_ack_cyc = cyc;
                end
                wb_cnt++;
            end else begin
                wb_cnt = 0;
            end
            if (mif.fill_req_o) begin
                if (fill_cnt == fill_delay) mif.fill_ack_i = 1'b1;
                fill_cnt++;
            end else begin
                fill_cnt = 0;
            end
            if (stray_ack && !mif.wb_req_o && !mif.fill_req_o) begin
                mif.wb_ack_i   = 1'b1;
                mif.fill_ack_i = 1'b1;
            end
        end
    end

    // monitor
    int pol_pulses = 0, we_cnt = 0, done_total = 0;
    bit wb_seen = 0, fill_seen = 0, ready_leak = 0;

    always @(negedge clock_i) begin
        if (!reset_i && mif.done_o) done_total++;
        if (!reset_i && sb.size() > 0) begin
            if (mif.req_ready_o) ready_leak = 1;
            if (mif.pol_miss_o) begin
                pol_pulses++;
                chk("pol_group", mif.pol_group_o, sb[0].grp);
            end
            if (mif.wb_req_o && !wb_seen) begin
                wb_seen = 1;
                chk("wb_addr", mif.wb_addr_o, {sb[0].old_tag, sb[0].grp});
            end
            if (mif.fill_req_o && !fill_seen) begin
                fill_seen = 1;
                chk("fill_addr", mif.fill_addr_o, {sb[0].tag, sb[0].grp});
                if (sb[0].dirty) chk("fill_after_wb_ack", cyc, wb_ack_cyc + 1);
            end
            if (mif.meta_we_o) begin
                we_cnt++;
                chk("meta_we_addr", mif.meta_addr_o, sb[0].victim);
                chk("meta_tag", mif.meta_tag_o, sb[0].tag);
            end
            if (mif.done_o) begin
                exp_t e;
                e = sb.pop_front();
                chk("victim", mif.victim_o, e.victim);
                chk("latency", cyc - e.t_acc, e.lat);
                chk("pol_pulses", pol_pulses, 1);
                chk("meta_we_count", we_cnt, 1);
                chk("wb_issued", wb_seen, e.dirty);
                chk("ready_low_busy", ready_leak, 0);
            end
        end
    end

    task automatic start_miss(input logic [BW_GRP-1:0] grp, input logic [BW_TAG-1:0] tag,
                              input logic [BW_CAP-1:0] v, input int pd, input int wd, input int fd,
                              input bit ba);
        exp_t e;
        @(negedge clock_i);
        cur_victim = v;
        pol_delay = pd; wb_delay = wd; fill_delay = fd; both_ack = ba;
        mif.req_group_i = grp;
        mif.req_tag_i   = tag;
        mif.req_valid_i = 1'b1;
        chk("ready_before_accept", mif.req_ready_o, 1);
        e.victim  = v;
        e.tag     = tag;
        e.grp     = grp;
        e.dirty   = m_valid[v] & m_dirty[v];
        e.old_tag = m_tag[v];
        e.lat     = 6 + pd + fd + (e.dirty ? 1 + wd : 0);
        e.t_acc   = cyc;
        @(posedge clock_i);
        #1;
        pol_pulses = 0; we_cnt = 0; wb_seen = 0; fill_seen = 0; ready_leak = 0;
        sb.push_back(e);
        @(negedge clock_i);
        mif.req_valid_i = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 80 && sb.size() > 0; i++) @(negedge clock_i);
        if (sb.size() > 0) begin
            chk("done_timeout", sb.size(), 0);
            sb.delete();
        end
    endtask

    task automatic run_miss(input logic [BW_GRP-1:0] grp, input logic [BW_TAG-1:0] tag,
                            input logic [BW_CAP-1:0] v, input int pd, input int wd, input int fd,
                            input bit ba);
        start_miss(grp, tag, v, pd, wd, fd, ba);
        wait_done();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        mif.req_valid_i = 1'b0;
        mif.req_group_i = '0;
        mif.req_tag_i   = '0;
        for (int i = 0; i < CAP; i++) set_meta(i, 1'b0, 1'b0, '0);

        repeat (3) @(negedge clock_i);
        chk("rst_ready", mif.req_ready_o, 0);
        chk("rst_ctrl", {mif.pol_miss_o, mif.meta_we_o, mif.wb_req_o, mif.fill_req_o, mif.done_o}, 0);
        chk("rst_addrs", {mif.pol_group_o, mif.meta_addr_o, mif.victim_o, mif.meta_tag_o}, 0);
        chk("rst_mem_addrs", {mif.wb_addr_o, mif.fill_addr_o}, 0);
        reset_i = 1'b0;
        @(negedge clock_i);
        chk("ready_after_reset", mif.req_ready_o, 1);

        // clean victim, immediate acks
        set_meta(7'h15, 1'b1, 1'b0, 20'h11111);
        run_miss(5'd5, 20'h12345, 7'h15, 0, 0, 0, 0);

        // dirty victim, writeback acked after 3 cycles
        set_meta(7'h2A, 1'b1, 1'b1, 20'h00ABC);
        run_miss(5'd10, 20'h54321, 7'h2A, 0, 3, 0, 0);
        chk("meta_cleaned", m_dirty[7'h2A], 0);

        // policy result delayed 4 cycles in CAP
        run_miss(5'd9, 20'hBEEF0, 7'h49, 4, 0, 1, 0);

        // writeback and fill ack together in WB, plus stray acks elsewhere
        set_meta(7'h33, 1'b1, 1'b1, 20'hCAFE1);
        stray_ack = 1;
        run_miss(5'd19, 20'h0F0F0, 7'h33, 1, 0, 2, 1);
        stray_ack = 0;

        // dirty bit without valid is not written back
        set_meta(7'h07, 1'b0, 1'b1, 20'h77777);
        run_miss(5'd7, 20'h00007, 7'h07, 0, 0, 0, 0);

        // four misses to group 3 walk through ways 0..3
        for (int w = 0; w < 4; w++)
            run_miss(5'd3, 20'hA0000 + 20'(w), 7'((w << 5) | 3), 0, 0, w, 0);

        // reset during writeback
        set_meta(7'h47, 1'b1, 1'b1, 20'h00777);
        start_miss(5'd7, 20'h13579, 7'h47, 0, 20, 0, 0);
        for (int i = 0; i < 20 && !mif.wb_req_o; i++) @(negedge clock_i);
        chk("wb_started", mif.wb_req_o, 1);
        @(negedge clock_i);
        #2 reset_i = 1'b1;
        #1;
        chk("wb_req_async_drop", mif.wb_req_o, 0);
        chk("ready_in_reset", mif.req_ready_o, 0);
        sb.delete();
        d0 = done_total;
        @(negedge clock_i);
        reset_i = 1'b0;
        @(negedge clock_i);
        chk("ready_after_abort", mif.req_ready_o, 1);
        repeat (8) @(negedge clock_i);
        chk("no_done_after_abort", done_total, d0);
        chk("victim_cleared", mif.victim_o, 0);

        // sequencer is usable again
        run_miss(5'd1, 20'h24680, 7'h21, 0, 0, 0, 0);

        repeat (2) @(negedge clock_i);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
